// File: rtl/nbcac_word_slicer.sv
// rtl/nbcac_word_slicer.sv - packs DIN_W-bit words LSB-first into 6-bit symbols for the NBCAC encoder
module nbcac_word_slicer #(
    parameter int DIN_W = 16
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic [DIN_W-1:0]                 din,
    input  logic                             din_valid,
    output logic                             din_ready,
    input  logic                             flush,
    output logic [5:0]                       dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [$clog2(2*DIN_W+1)-1:0]     fill
);

    localparam int FW = $clog2(2*DIN_W+1);
    localparam int BW = 2*DIN_W;
    localparam logic [FW-1:0] SYM_W  = FW'(6);
    localparam logic [FW-1:0] WORD_W = FW'(DIN_W);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   sbuf;
    logic [BW-1:0]   buf_next;
    logic [BW-1:0]   word_ext;
    logic [FW-1:0]   fill_pop;
    logic [FW-1:0]   fill_next;
    logic            flush_pending;
    logic            push;
    logic            pop;

    // Bits at or above fill are kept zero, so buffer[5:0] is already zero-padded.
    assign flush_pending = (state == DRAIN);
    assign din_ready     = (fill <= WORD_W) && !flush_pending;
    assign dout_valid    = (fill >= SYM_W) || (flush_pending && (fill != '0));
    assign dout          = sbuf[5:0];
    assign push          = din_valid && din_ready;
    assign pop           = dout_valid && dout_ready;

    always_comb begin
        buf_next   = sbuf;
        fill_pop   = fill;
        word_ext   = {{DIN_W{1'b0}}, din};
        state_next = state;

        if (pop) begin
            buf_next = sbuf >> 6;
            fill_pop = (fill >= SYM_W) ? (fill - SYM_W) : '0;
        end

        fill_next = fill_pop;
        // Push lands after the popped bits; din_ready guarantees fill_pop <= DIN_W here.
        if (push) begin
            buf_next  = buf_next | (word_ext << fill_pop);
            fill_next = fill_pop + WORD_W;
        end

        case (state)
            DRAIN: begin
                if (fill_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (flush) begin
                    state_next = DRAIN;
                end else if (fill_next == '0) begin
                    state_next = IDLE;
                end else begin
                    state_next = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sbuf <= '0;
            fill <= '0;
        end else begin
            sbuf <= buf_next;
            fill <= fill_next;
        end
    end

endmodule

// File: tb/tb_nbcac_word_slicer.sv
// tb/tb_nbcac_word_slicer.sv - directed self-checking bench for nbcac_word_slicer (DIN_W=16)
module tb_nbcac_word_slicer;

    logic        clock = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        flush;
    logic [5:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [5:0]  fill;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [5:0]  got[$];
    logic        acc;
    logic [63:0] model;

    always #5 clock = ~clock;

    nbcac_word_slicer #(.DIN_W(16)) dut (
        .clock      (clock),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fill       (fill)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] sym_of(input logic [63:0] v, input int i);
        logic [63:0] t;
        t = v >> (6*i);
        return t[5:0];
    endfunction

    function automatic logic [63:0] got_at(input int i);
        if (i < got.size()) return 64'(got[i]);
        return 64'hDEAD;
    endfunction

    // Called just after a rising edge; records the symbol that the next edge pops.
    task automatic cycle(input logic v, input logic [15:0] d, input logic fl, output logic accepted);
        din_valid = v;
        din       = d;
        flush     = fl;
        accepted  = v && din_ready;
        if (dout_valid && dout_ready) got.push_back(dout);
        @(posedge clock);
        #1;
        din_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, w, 1'b0, a);
            if (a) break;
        end
        check_eq($sformatf("push_%04h_accepted", w), 64'(a), 64'd1);
    endtask

    task automatic drain(input string tag);
        logic a;
        for (int i = 0; i < 30; i++) begin
            if (!dout_valid && fill == 6'd0) break;
            cycle(1'b0, 16'h0, 1'b0, a);
        end
        check_eq({tag, "_fill_zero"}, 64'(fill), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        din        = 16'h0;
        din_valid  = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b0;

        #12;
        check_eq("rst_fill",       64'(fill),       64'd0);
        check_eq("rst_dout_valid", 64'(dout_valid), 64'd0);
        check_eq("rst_din_ready",  64'(din_ready),  64'd1);
        check_eq("rst_dout",       64'(dout),       64'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;

        // Streaming three words with the sink always ready
        dout_ready = 1'b1;
        got.delete();
        push_word(16'hABCD);
        push_word(16'h1234);
        push_word(16'h5678);
        drain("stream");
        check_eq("stream_count", 64'(got.size()), 64'd8);
        check_eq("stream_sym0_hand", got_at(0), 64'h0D);
        check_eq("stream_sym1_hand", got_at(1), 64'h2F);
        check_eq("stream_sym2_hand", got_at(2), 64'h0A);
        model = 64'h0000_5678_1234_ABCD;
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("stream_sym%0d", i), got_at(i), 64'(sym_of(model, i)));

        // Flush of a partial word
        got.delete();
        push_word(16'h00FF);
        cycle(1'b0, 16'h0, 1'b1, acc);
        check_eq("flush_din_ready_low", 64'(din_ready), 64'd0);
        drain("flush");
        check_eq("flush_count", 64'(got.size()), 64'd3);
        check_eq("flush_sym0", got_at(0), 64'h3F);
        check_eq("flush_sym1", got_at(1), 64'h03);
        check_eq("flush_sym2", got_at(2), 64'h00);
        check_eq("flush_din_ready", 64'(din_ready), 64'd1);

        // Backpressure fills the buffer to its limit
        dout_ready = 1'b0;
        got.delete();
        push_word(16'hFFFF);
        push_word(16'hFFFF);
        check_eq("bp_fill",       64'(fill),       64'd32);
        check_eq("bp_din_ready",  64'(din_ready),  64'd0);
        check_eq("bp_dout_valid", 64'(dout_valid), 64'd1);
        check_eq("bp_dout",       64'(dout),       64'h3F);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'h0000, 1'b0, acc);
            check_eq($sformatf("bp_hold_accept%0d", i), 64'(acc),  64'd0);
            check_eq($sformatf("bp_hold_fill%0d", i),   64'(fill), 64'd32);
            check_eq($sformatf("bp_hold_dout%0d", i),   64'(dout), 64'h3F);
        end

        // Release backpressure
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0, 1'b0, acc);
            if (i == 1) check_eq("rel_din_ready_fill20", 64'(din_ready), 64'd0);
            if (i == 2) check_eq("rel_din_ready_fill14", 64'(din_ready), 64'd1);
        end
        check_eq("rel_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("rel_sym%0d", i), got_at(i), 64'h3F);
        check_eq("rel_fill",       64'(fill),       64'd2);
        check_eq("rel_dout_valid", 64'(dout_valid), 64'd0);
        cycle(1'b0, 16'h0, 1'b0, acc);
        cycle(1'b0, 16'h0, 1'b0, acc);
        check_eq("rel_no_early_tail", 64'(got.size()), 64'd5);
        cycle(1'b0, 16'h0, 1'b1, acc);
        drain("rel");
        check_eq("rel_tail_count", 64'(got.size()), 64'd6);
        check_eq("rel_tail_sym",   got_at(5),        64'h03);

        // Pop and push in the same cycle at fill=16
        got.delete();
        dout_ready = 1'b0;
        push_word(16'h1A2B);
        dout_ready = 1'b1;
        cycle(1'b1, 16'hC3D5, 1'b0, acc);
        check_eq("pp_accept", 64'(acc),  64'd1);
        check_eq("pp_fill",   64'(fill), 64'd26);
        cycle(1'b0, 16'h0, 1'b1, acc);
        drain("pp");
        check_eq("pp_count", 64'(got.size()), 64'd6);
        model = 64'h0000_0000_C3D5_1A2B;
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("pp_sym%0d", i), got_at(i), 64'(sym_of(model, i)));

        // Flush with an empty buffer
        cycle(1'b0, 16'h0, 1'b1, acc);
        check_eq("eflush_din_ready",  64'(din_ready),  64'd0);
        check_eq("eflush_dout_valid", 64'(dout_valid), 64'd0);
        cycle(1'b0, 16'h0, 1'b0, acc);
        check_eq("eflush_recover", 64'(din_ready), 64'd1);

        // Asynchronous reset mid-operation
        got.delete();
        dout_ready = 1'b1;
        push_word(16'h5555);
        cycle(1'b0, 16'h0, 1'b0, acc);
        dout_ready = 1'b0;
        check_eq("mrst_fill_before", 64'(fill), 64'd10);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_fill",       64'(fill),       64'd0);
        check_eq("mrst_dout_valid", 64'(dout_valid), 64'd0);
        check_eq("mrst_din_ready",  64'(din_ready),  64'd1);
        check_eq("mrst_dout",       64'(dout),       64'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        dout_ready = 1'b1;
        push_word(16'h0001);
        check_eq("mrst_new_valid", 64'(dout_valid), 64'd1);
        check_eq("mrst_new_dout",  64'(dout),       64'h01);
        check_eq("mrst_new_fill",  64'(fill),       64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
